// File: rtl/oam_port_arb.sv
// OAM port arbiter and DMA write sequencer.
// It shares the single OAM SRAM port among DMA byte writes, PPU word reads and
// CPU byte accesses. Requests sampled on one edge own the port for the
// following cycle. Read data returns one cycle after the SRAM access.
module oam_port_arb #(
  parameter int OAM_BYTES = 160
) (
  input  logic        clk1,
  input  logic        nreset6,
  input  logic        dma_run,
  input  logic        dma_step,
  input  logic [7:0]  dma_a_lo,
  input  logic [7:0]  dma_din,
  input  logic        ppu_req,
  input  logic [6:0]  ppu_a,
  output logic [15:0] ppu_dout,
  output logic        ppu_rvalid,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_a,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_rvalid,
  output logic [6:0]  oam_a,
  output logic        oam_we_l,
  output logic        oam_we_h,
  output logic [7:0]  oam_wdata,
  input  logic [15:0] oam_rdata,
  output logic [7:0]  dma_wr_cnt,
  output logic        dma_done
);

  localparam logic [8:0] LIM  = 9'(OAM_BYTES);
  localparam logic [8:0] LAST = 9'(OAM_BYTES - 1);

  // CPU read response kinds, resolved at grant time and applied one cycle later
  localparam logic [1:0] RSP_DATA = 2'd0;
  localparam logic [1:0] RSP_BLK  = 2'd1;
  localparam logic [1:0] RSP_ZERO = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DMA_WR,
    S_PPU_RD,
    S_CPU_RD,
    S_CPU_WR
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  oam_a_q, oam_a_d;
  logic        we_l_q, we_l_d;
  logic        we_h_q, we_h_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        ppu_pend_q, ppu_pend_d;
  logic        ppu_blk_q, ppu_blk_d;
  logic        cpu_pend_q, cpu_pend_d;
  logic [1:0]  cpu_kind_q, cpu_kind_d;
  logic        cpu_lane_q, cpu_lane_d;
  logic [15:0] ppu_dout_q, ppu_dout_d;
  logic        ppu_rvalid_q, ppu_rvalid_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;

  logic lock;
  logic dma_in_rng;
  logic cpu_in_rng;
  logic dma_last;

  // Lockout covers a running DMA, a step arriving now, and a write still in its slot
  // (the last case keeps the lockout alive for the cycle after dma_run falls).
  assign lock       = dma_run | dma_step | (state_q == S_DMA_WR);
  assign dma_in_rng = ({1'b0, dma_a_lo} < LIM);
  assign cpu_in_rng = ({1'b0, cpu_a} < LIM);
  assign dma_last   = ({1'b0, dma_a_lo} == LAST);

  // Grant selection and SRAM port drive for the next cycle, plus response tagging
  always_comb begin
    state_d    = S_IDLE;
    oam_a_d    = oam_a_q;
    we_l_d     = 1'b0;
    we_h_d     = 1'b0;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    ppu_pend_d = ppu_req;
    ppu_blk_d  = lock;
    cpu_pend_d = cpu_req & ~cpu_wr;
    cpu_lane_d = cpu_a[0];
    cpu_kind_d = RSP_DATA;

    // Every DMA slot counts, including out-of-range offsets; idle DMA clears
    if (dma_step) begin
      if (cnt_q != 8'hFF) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (!dma_run) begin
      cnt_d = 8'h00;
    end

    if (lock || ppu_req) begin
      cpu_kind_d = RSP_BLK;
    end else if (!cpu_in_rng) begin
      cpu_kind_d = RSP_ZERO;
    end

    if (dma_step) begin
      state_d = S_DMA_WR;
      oam_a_d = dma_a_lo[7:1];
      wdata_d = dma_din;
      if (dma_in_rng) begin
        we_l_d = ~dma_a_lo[0];
        we_h_d = dma_a_lo[0];
      end
      done_d  = dma_last;
    end else if (ppu_req && !lock) begin
      state_d = S_PPU_RD;
      oam_a_d = ppu_a;
    end else if (cpu_req && !lock && cpu_in_rng) begin
      oam_a_d = cpu_a[7:1];
      if (cpu_wr) begin
        state_d = S_CPU_WR;
        wdata_d = cpu_din;
        we_l_d  = ~cpu_a[0];
        we_h_d  = cpu_a[0];
      end else begin
        state_d = S_CPU_RD;
      end
    end
  end

  // Read return stage: capture SRAM data (or the substituted value) one cycle after access
  always_comb begin
    ppu_rvalid_d = ppu_pend_q;
    cpu_rvalid_d = cpu_pend_q;
    ppu_dout_d   = ppu_dout_q;
    cpu_dout_d   = cpu_dout_q;
    if (ppu_pend_q) begin
      ppu_dout_d = ppu_blk_q ? 16'hFFFF : oam_rdata;
    end
    if (cpu_pend_q) begin
      case (cpu_kind_q)
        RSP_BLK:  cpu_dout_d = 8'hFF;
        RSP_ZERO: cpu_dout_d = 8'h00;
        default:  cpu_dout_d = cpu_lane_q ? oam_rdata[15:8] : oam_rdata[7:0];
      endcase
    end
  end

  // State and output registers; async reset drops any pending write at once
  always_ff @(posedge clk1 or negedge nreset6) begin
    if (!nreset6) begin
      state_q      <= S_IDLE;
      oam_a_q      <= 7'd0;
      we_l_q       <= 1'b0;
      we_h_q       <= 1'b0;
      wdata_q      <= 8'd0;
      cnt_q        <= 8'd0;
      done_q       <= 1'b0;
      ppu_pend_q   <= 1'b0;
      ppu_blk_q    <= 1'b0;
      cpu_pend_q   <= 1'b0;
      cpu_kind_q   <= RSP_DATA;
      cpu_lane_q   <= 1'b0;
      ppu_dout_q   <= 16'd0;
      ppu_rvalid_q <= 1'b0;
      cpu_dout_q   <= 8'd0;
      cpu_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      oam_a_q      <= oam_a_d;
      we_l_q       <= we_l_d;
      we_h_q       <= we_h_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      ppu_pend_q   <= ppu_pend_d;
      ppu_blk_q    <= ppu_blk_d;
      cpu_pend_q   <= cpu_pend_d;
      cpu_kind_q   <= cpu_kind_d;
      cpu_lane_q   <= cpu_lane_d;
      ppu_dout_q   <= ppu_dout_d;
      ppu_rvalid_q <= ppu_rvalid_d;
      cpu_dout_q   <= cpu_dout_d;
      cpu_rvalid_q <= cpu_rvalid_d;
    end
  end

  assign oam_a      = oam_a_q;
  assign oam_we_l   = we_l_q;
  assign oam_we_h   = we_h_q;
  assign oam_wdata  = wdata_q;
  assign dma_wr_cnt = cnt_q;
  assign dma_done   = done_q;
  assign ppu_dout   = ppu_dout_q;
  assign ppu_rvalid = ppu_rvalid_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_oam_port_arb.sv
// Scoreboard bench for oam_port_arb with a behavioural OAM SRAM model.
module tb_oam_port_arb;

  logic        clk1 = 1'b0;
  logic        nreset6;
  logic        dma_run, dma_step;
  logic [7:0]  dma_a_lo, dma_din;
  logic        ppu_req;
  logic [6:0]  ppu_a;
  logic [15:0] ppu_dout;
  logic        ppu_rvalid;
  logic        cpu_req, cpu_wr;
  logic [7:0]  cpu_a, cpu_din, cpu_dout;
  logic        cpu_rvalid;
  logic [6:0]  oam_a;
  logic        oam_we_l, oam_we_h;
  logic [7:0]  oam_wdata;
  logic [15:0] oam_rdata;
  logic [7:0]  dma_wr_cnt;
  logic        dma_done;

  oam_port_arb #(.OAM_BYTES(160)) dut (
    .clk1(clk1), .nreset6(nreset6),
    .dma_run(dma_run), .dma_step(dma_step), .dma_a_lo(dma_a_lo), .dma_din(dma_din),
    .ppu_req(ppu_req), .ppu_a(ppu_a), .ppu_dout(ppu_dout), .ppu_rvalid(ppu_rvalid),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_a(cpu_a), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_rvalid(cpu_rvalid),
    .oam_a(oam_a), .oam_we_l(oam_we_l), .oam_we_h(oam_we_h), .oam_wdata(oam_wdata),
    .oam_rdata(oam_rdata), .dma_wr_cnt(dma_wr_cnt), .dma_done(dma_done)
  );

  always #5 clk1 = ~clk1;

  // SRAM model: asynchronous read, byte-lane writes on the rising edge
  logic [15:0] mem [0:127];
  assign oam_rdata = mem[oam_a];
  always @(posedge clk1) begin
    if (oam_we_l) mem[oam_a][7:0]  <= oam_wdata;
    if (oam_we_h) mem[oam_a][15:8] <= oam_wdata;
  end

  int cyc = 0;
  always @(posedge clk1) cyc <= cyc + 1;

  typedef struct { logic [6:0] a; logic h; logic [7:0] d; int due; } wr_t;
  typedef struct { logic [15:0] d; int due; } rd_t;
  wr_t exp_wr[$];
  rd_t exp_ppu[$];
  rd_t exp_cpu[$];
  int  exp_done[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe, valid or done
  always @(negedge clk1) begin
    if (oam_we_l || oam_we_h) begin
      if (exp_wr.size() == 0) begin
        chk("unexpected_strobe", {oam_we_h, oam_we_l, 1'b0, oam_a, oam_wdata}, 32'h0);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        chk("wr_addr", {25'd0, oam_a}, {25'd0, w.a});
        chk("wr_lane", {30'd0, oam_we_h, oam_we_l}, w.h ? 32'd2 : 32'd1);
        chk("wr_data", {24'd0, oam_wdata}, {24'd0, w.d});
        chk("wr_cycle", cyc, w.due);
      end
    end
    if (ppu_rvalid) begin
      if (exp_ppu.size() == 0) begin
        chk("unexpected_ppu_rvalid", {16'd0, ppu_dout}, 32'hDEAD_0000);
      end else begin
        rd_t r;
        r = exp_ppu.pop_front();
        chk("ppu_dout", {16'd0, ppu_dout}, {16'd0, r.d});
        chk("ppu_cycle", cyc, r.due);
      end
    end
    if (cpu_rvalid) begin
      if (exp_cpu.size() == 0) begin
        chk("unexpected_cpu_rvalid", {24'd0, cpu_dout}, 32'hDEAD_0000);
      end else begin
        rd_t r;
        r = exp_cpu.pop_front();
        chk("cpu_dout", {24'd0, cpu_dout}, {16'd0, r.d});
        chk("cpu_cycle", cyc, r.due);
      end
    end
    if (dma_done) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_dma_done", cyc, 32'hFFFF_FFFF);
      end else begin
        chk("dma_done_cycle", cyc, exp_done.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic dma_issue(input logic [7:0] o, input logic [7:0] d);
    dma_step = 1'b1; dma_a_lo = o; dma_din = d;
    if (o < 8'd160) exp_wr.push_back('{a: o[7:1], h: o[0], d: d, due: cyc + 1});
    if (o == 8'd159) exp_done.push_back(cyc + 1);
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_a = a;
    exp_cpu.push_back('{d: {8'd0, exp}, due: cyc + 2});
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d, input logic lands);
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_a = a; cpu_din = d;
    if (lands) exp_wr.push_back('{a: a[7:1], h: a[0], d: d, due: cyc + 1});
    tick();
    cpu_req = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic ppu_read(input logic [6:0] a, input logic [15:0] exp);
    ppu_req = 1'b1; ppu_a = a;
    exp_ppu.push_back('{d: exp, due: cyc + 2});
    tick();
    ppu_req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_strobes"}, {30'd0, oam_we_h, oam_we_l}, 32'd0);
    chk({tag, "_valids"}, {30'd0, ppu_rvalid, cpu_rvalid}, 32'd0);
    chk({tag, "_dma_done"}, {31'd0, dma_done}, 32'd0);
    chk({tag, "_oam_a"}, {25'd0, oam_a}, 32'd0);
    chk({tag, "_oam_wdata"}, {24'd0, oam_wdata}, 32'd0);
    chk({tag, "_dma_wr_cnt"}, {24'd0, dma_wr_cnt}, 32'd0);
    chk({tag, "_ppu_dout"}, {16'd0, ppu_dout}, 32'd0);
    chk({tag, "_cpu_dout"}, {24'd0, cpu_dout}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
    nreset6 = 1'b0;
    dma_run = 1'b0; dma_step = 1'b0; dma_a_lo = 8'd0; dma_din = 8'd0;
    ppu_req = 1'b0; ppu_a = 7'd0;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_a = 8'd0; cpu_din = 8'd0;
    idle(3);
    chk_reset_vals("reset");
    nreset6 = 1'b1;
    idle(2);

    // Full 160-byte DMA on consecutive cycles
    dma_run = 1'b1;
    tick();
    for (int o = 0; o < 160; o++) begin
      dma_issue(8'(o), 8'(o) ^ 8'h5A);
      tick();
    end
    dma_step = 1'b0;
    idle(3);
    chk("dma_wr_cnt_full", {24'd0, dma_wr_cnt}, 32'd160);
    dma_run = 1'b0;
    idle(2);
    chk("dma_wr_cnt_cleared", {24'd0, dma_wr_cnt}, 32'd0);
    cpu_read(8'h37, 8'h6D);
    idle(3);

    // CPU write/read with no DMA, then blocked access during DMA
    cpu_write(8'h10, 8'h42, 1'b1);
    idle(2);
    cpu_read(8'h10, 8'h42);
    idle(2);
    dma_run = 1'b1;
    tick();
    cpu_read(8'h10, 8'hFF);
    cpu_write(8'h10, 8'h99, 1'b0);
    ppu_read(7'h08, 16'hFFFF);
    idle(2);
    dma_run = 1'b0;
    idle(2);
    cpu_read(8'h10, 8'h42);
    idle(2);

    // PPU reads, alone and colliding with a CPU read
    ppu_read(7'h1B, 16'h6D6C);
    ppu_req = 1'b1; ppu_a = 7'h08;
    exp_ppu.push_back('{d: 16'h4B42, due: cyc + 2});
    cpu_read(8'h20, 8'hFF);
    ppu_req = 1'b0;
    idle(3);

    // Out-of-range CPU and DMA offsets
    cpu_read(8'hA5, 8'h00);
    cpu_write(8'hA5, 8'h33, 1'b0);
    idle(2);
    dma_run = 1'b1;
    tick();
    dma_issue(8'hA0, 8'hEE);
    tick();
    dma_step = 1'b0;
    idle(1);
    chk("dma_wr_cnt_oor", {24'd0, dma_wr_cnt}, 32'd1);
    dma_run = 1'b0;
    idle(2);

    // dma_run falls on the same edge as the final step
    dma_run = 1'b1;
    tick();
    dma_issue(8'h9D, 8'h11); tick();
    dma_issue(8'h9E, 8'h22); tick();
    dma_issue(8'h9F, 8'h77); tick();
    dma_step = 1'b0; dma_run = 1'b0;
    cpu_read(8'h00, 8'hFF);
    idle(2);
    cpu_read(8'h9F, 8'h77);
    cpu_read(8'h9E, 8'h22);
    cpu_read(8'h00, 8'h5A);
    idle(3);

    // Reset pulse between a DMA step and its write slot
    dma_run = 1'b1;
    tick();
    dma_step = 1'b1; dma_a_lo = 8'h20; dma_din = 8'hC3;
    #3;
    nreset6 = 1'b0;
    tick();
    chk_reset_vals("midreset");
    dma_step = 1'b0; dma_run = 1'b0;
    tick();
    nreset6 = 1'b1;
    idle(2);
    cpu_read(8'h20, 8'h20 ^ 8'h5A);
    idle(4);

    chk("wr_queue_drained", exp_wr.size(), 32'd0);
    chk("ppu_queue_drained", exp_ppu.size(), 32'd0);
    chk("cpu_queue_drained", exp_cpu.size(), 32'd0);
    chk("done_queue_drained", exp_done.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oam_port_arb.md
# oam_port_arb

OAM port arbiter and DMA write sequencer, directly downstream of the OAM DMA controller. It takes the controller's low address byte, its per-byte step strobe and the fetched source byte, and turns them into OAM SRAM writes. It also arbitrates the single OAM SRAM port among three masters: DMA writes, PPU sprite-scan reads (16-bit word) and CPU byte accesses to FE00–FEFF. CPU and PPU are locked out while DMA runs.

## Interface
Parameters:
- OAM_BYTES, 160: OAM size in bytes; byte addresses at or above this value are unusable.

Ports:
- clk1  in  1  system clock; all state updates on the rising edge.
- nreset6  in  1  reset, asynchronous and active-low.
- dma_run  in  1  DMA in progress, from the DMA controller.
- dma_step  in  1  one-cycle pulse: dma_din holds the source byte for address dma_a_lo.
- dma_a_lo  in  8  DMA destination offset (0x00–0x9F).
- dma_din  in  8  fetched source byte.
- ppu_req  in  1  PPU word read request.
- ppu_a  in  7  PPU word address (byte address bits 7:1).
- ppu_dout  out  16  PPU read data; high byte = odd address.
- ppu_rvalid  out  1  PPU read data valid pulse.
- cpu_req  in  1  CPU OAM access request (FE00–FEFF decoded upstream).
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_a  in  8  CPU byte offset.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data.
- cpu_rvalid  out  1  CPU read data valid pulse.
- oam_a  out  7  SRAM word address (registered).
- oam_we_l  out  1  write strobe, even byte lane.
- oam_we_h  out  1  write strobe, odd byte lane.
- oam_wdata  out  8  write data, driven on both lanes.
- oam_rdata  in  16  SRAM read data; asynchronous read of oam_a.
- dma_wr_cnt  out  8  DMA bytes written since dma_run rose.
- dma_done  out  1  one-cycle pulse on the write to offset OAM_BYTES-1.

## Operation
- Requests are sampled on edge E. The SRAM port is granted for the cycle after E.
- Grant priority, highest first:
  - pending DMA write;
  - PPU read;
  - CPU access.
- DMA pipeline:
  - dma_step at E latches dma_a_lo and dma_din into a one-entry write buffer.
  - In the next cycle the buffer drives oam_a = a[7:1], with oam_we_l if a[0]=0 or oam_we_h if a[0]=1, and oam_wdata = data.
  - Back-to-back dma_step pulses are accepted every cycle without loss.
  - If the offset is ≥ OAM_BYTES: no strobe. dma_wr_cnt still increments.
- dma_wr_cnt:
  - Increments on every DMA write slot.
  - Clears while dma_run=0.
  - Saturates at 0xFF.
- Lockout: while dma_run=1 or a DMA write is pending:
  - PPU reads complete with ppu_dout=16'hFFFF.
  - CPU reads complete with cpu_dout=8'hFF.
  - CPU writes are dropped.
  - No SRAM access occurs for either.
- PPU read: oam_a=ppu_a in the granted cycle. oam_rdata is captured at the end of that cycle.
- CPU:
  - cpu_a < OAM_BYTES: byte read from the lane selected by cpu_a[0], or byte write on that lane.
  - cpu_a ≥ OAM_BYTES: read returns 8'h00 with no SRAM access; write is dropped.
  - CPU loses to PPU in the same cycle: read returns 8'hFF, write is dropped.
- Grant state machine:
  - States: IDLE, DMA_WR, PPU_RD, CPU_RD, CPU_WR.
  - The next state is chosen each edge from the priority rules.
  - The state returns to IDLE when no request is present.

## Timing
- Reset values:
  - all strobes, valids, dma_done = 0;
  - oam_a = 0, oam_wdata = 0, dma_wr_cnt = 0;
  - ppu_dout = 0, cpu_dout = 0;
  - write buffer empty, state IDLE.
- Reset asserted mid-transfer discards the pending write. No strobe is issued after nreset6 falls.
- DMA: dma_step at E → write strobe high in cycle E+1, exactly one cycle.
- dma_done is coincident with that strobe when the offset is OAM_BYTES-1.
- Reads: request at E → SRAM access in cycle E+1 → rvalid high and data valid in cycle E+2, for one cycle.
- Blocked and out-of-range reads have the same latency: rvalid in cycle E+2.
- CPU write: request at E → strobe in cycle E+1.
- dma_run falling with a write pending: the pending write still completes, and lockout lasts through that cycle.

## Test plan
- Full DMA, 160 dma_step pulses on consecutive cycles with offsets 0x00..0x9F and data = offset ^ 0x5A → each strobe lands on the correct lane; a CPU readback of FE37 after dma_run=0 returns 0x6D; dma_done pulses once; dma_wr_cnt = 160.
- CPU read of FE10 (holding 0x42) during dma_run=1 → cpu_dout = 0xFF at E+2, no SRAM access. CPU write during dma_run=1 → memory unchanged.
- PPU and CPU request in the same cycle, no DMA → PPU gets its word at E+2; CPU read returns 0xFF.
- CPU read of FEA5 → 0x00 at E+2. CPU write of FEA5 → no strobe. DMA step at offset 0xA0 → no strobe, count increments.
- nreset6 pulsed low in the cycle between dma_step and its write → no strobe; all outputs at reset values.
- dma_run drops on the same edge as the last dma_step (offset 0x9F) → write to word 0x4F with oam_we_h is still performed; a CPU read requested in that cycle returns 0xFF.
